// File: rtl/motor_pkg.sv
// motor_pkg: action codes, default servo timing constants and the action-to-width
// decode shared by motor_drive and the upstream line-following controller.
package motor_pkg;

  localparam int unsigned WIDTH_W                = 21;
  localparam int unsigned DEFAULT_PERIOD_CYCLES  = 2_000_000;
  localparam int unsigned DEFAULT_NEUTRAL_CYCLES = 150_000;
  localparam int unsigned DEFAULT_DELTA_CYCLES   = 50_000;
  localparam int unsigned DEFAULT_RAMP_STEP      = 5_000;

  typedef logic [WIDTH_W-1:0] width_t;

  typedef enum logic [2:0] {
    STOP     = 3'd0,
    FORWARD  = 3'd1,
    RIGHT    = 3'd2,
    LEFT     = 3'd3,
    SPIN     = 3'd4,
    BACKWARD = 3'd5
  } action_t;

  typedef struct packed {
    width_t l;
    width_t r;
  } widths_t;

  // Right servo is mounted mirrored: forward on that wheel is a shorter pulse.
  // Codes 110/111 fall through to the stop widths.
  function automatic widths_t decode_action(input action_t action,
                                            input width_t  neutral,
                                            input width_t  delta);
    widths_t w;
    w.l = neutral;
    w.r = neutral;
    case (action)
      FORWARD:  begin w.l = neutral + delta; w.r = neutral - delta; end
      RIGHT:    begin w.l = neutral + delta; w.r = neutral;         end
      LEFT:     begin w.l = neutral;         w.r = neutral - delta; end
      SPIN:     begin w.l = neutral + delta; w.r = neutral + delta; end
      BACKWARD: begin w.l = neutral - delta; w.r = neutral + delta; end
      default:  begin w.l = neutral;         w.r = neutral;         end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/motor_drive_servo_pwm_channel.sv
// servo_pwm_channel: per-wheel width register, optional soft-start ramp and pulse
// comparator. Soft start is enabled by defining MOTOR_SOFT_START_EN.
module servo_pwm_channel
  import motor_pkg::*;
#(
  parameter int unsigned NEUTRAL_CYCLES = DEFAULT_NEUTRAL_CYCLES,
  parameter int unsigned RAMP_STEP      = DEFAULT_RAMP_STEP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample,
  input  logic [WIDTH_W-1:0] cnt,
  input  logic [WIDTH_W-1:0] target,
  output logic               pwm
);

`ifdef MOTOR_SOFT_START_EN
  localparam bit SOFT_START = 1'b1;
`else
  localparam bit SOFT_START = 1'b0;
`endif

  // Without soft start the step is unbounded, so the ramp loads the target directly.
  localparam width_t STEP    = SOFT_START ? width_t'(RAMP_STEP) : '1;
  localparam width_t NEUTRAL = width_t'(NEUTRAL_CYCLES);

  width_t width_q;
  width_t width_next;

  always_comb begin
    width_next = width_q;
    if (sample) begin
      if (target > width_q)
        width_next = ((target - width_q) > STEP) ? width_q + STEP : target;
      else
        width_next = ((width_q - target) > STEP) ? width_q - STEP : target;
    end
  end

  // Comparing against width_next lets the boundary cycle already use the new width.
  always_ff @(posedge clk) begin
    if (reset) begin
      width_q <= NEUTRAL;
      pwm     <= 1'b0;
    end else begin
      width_q <= width_next;
      pwm     <= (cnt < width_next);
    end
  end

endmodule

// File: rtl/motor_drive.sv
// motor_drive: two-channel 50 Hz servo PWM stage driven by the controller's action code.
// Optional soft start (per-period width ramp) is enabled by defining MOTOR_SOFT_START_EN.
module motor_drive
  import motor_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES  = DEFAULT_PERIOD_CYCLES,
  parameter int unsigned NEUTRAL_CYCLES = DEFAULT_NEUTRAL_CYCLES,
  parameter int unsigned DELTA_CYCLES   = DEFAULT_DELTA_CYCLES,
  parameter int unsigned RAMP_STEP      = DEFAULT_RAMP_STEP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] output_action,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       period_start
);

  localparam width_t PERIOD_LAST = width_t'(PERIOD_CYCLES - 1);
  localparam width_t NEUTRAL     = width_t'(NEUTRAL_CYCLES);
  localparam width_t DELTA       = width_t'(DELTA_CYCLES);

  width_t  cnt;
  logic    boundary;
  widths_t target;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (cnt == PERIOD_LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign boundary     = (cnt == '0);
  // cnt rests at 0 during reset, so the strobe is masked there.
  assign period_start = boundary && !reset;

  always_comb begin
    target = decode_action(action_t'(output_action), NEUTRAL, DELTA);
  end

  servo_pwm_channel #(
    .NEUTRAL_CYCLES(NEUTRAL_CYCLES),
    .RAMP_STEP     (RAMP_STEP)
  ) u_left (
    .clk   (clk),
    .reset (reset),
    .sample(boundary),
    .cnt   (cnt),
    .target(target.l),
    .pwm   (pwm_l)
  );

  servo_pwm_channel #(
    .NEUTRAL_CYCLES(NEUTRAL_CYCLES),
    .RAMP_STEP     (RAMP_STEP)
  ) u_right (
    .clk   (clk),
    .reset (reset),
    .sample(boundary),
    .cnt   (cnt),
    .target(target.r),
    .pwm   (pwm_r)
  );

endmodule

// File: tb/tb_motor_drive.sv
// tb_motor_drive: per-cycle comparison against a period-level behavioural model,
// plus measured pulse widths pinned to hand-computed values. Follows MOTOR_SOFT_START_EN.
module tb_motor_drive;

  localparam int unsigned P = 200;
  localparam int unsigned N = 60;
  localparam int unsigned D = 20;
  localparam int unsigned R = 5;

`ifdef MOTOR_SOFT_START_EN
  localparam bit SOFT = 1'b1;
  int ramp_l[5] = '{65, 70, 75, 80, 80};
  int ramp_r[5] = '{55, 50, 45, 40, 40};
`else
  localparam bit SOFT = 1'b0;
  int ramp_l[5] = '{80, 80, 80, 80, 80};
  int ramp_r[5] = '{40, 40, 40, 40, 40};
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] output_action = 3'd0;
  logic       pwm_l, pwm_r, period_start;

  int tests = 0;
  int fails = 0;

  motor_drive #(
    .PERIOD_CYCLES (P),
    .NEUTRAL_CYCLES(N),
    .DELTA_CYCLES  (D),
    .RAMP_STEP     (R)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .output_action(output_action),
    .pwm_l        (pwm_l),
    .pwm_r        (pwm_r),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: wheel offsets in units of D per action code (6/7 = stop).
  int l_off[8] = '{0, 1, 1, 0, 1, -1, 0, 0};
  int r_off[8] = '{0, -1, 0, -1, 1, 1, 0, 0};
  int m_wl = N, m_wr = N, m_ph = 0;
  bit m_el = 0, m_er = 0, m_valid = 0;

  function automatic int approach(input int cur, input int tgt);
    int step = SOFT ? R : P;
    if (tgt > cur + step) return cur + step;
    if (tgt < cur - step) return cur - step;
    return tgt;
  endfunction

  always @(posedge clk) begin
    m_valid = 1;
    if (reset) begin
      m_wl = N; m_wr = N; m_ph = 0; m_el = 0; m_er = 0;
    end else begin
      if (m_ph == 0) begin
        m_wl = approach(m_wl, N + l_off[output_action] * D);
        m_wr = approach(m_wr, N + r_off[output_action] * D);
      end
      // Pulse is high for the first width cycles following each boundary.
      m_el = (m_ph < m_wl);
      m_er = (m_ph < m_wr);
      m_ph = (m_ph + 1) % P;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_pwm_l", pwm_l, m_el);
      check("cyc_pwm_r", pwm_r, m_er);
      check("cyc_period_start", period_start, (!reset && m_ph == 0));
    end
  end

  task automatic wait_ps(output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * P + 4; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL wait_period_start: got no strobe expected one within %0d cycles", 2 * P + 4);
    end
  endtask

  // Counts one period's high cycles; aligned means we already sit on a strobe negedge.
  task automatic measure(input string name, input int exp_l, input int exp_r,
                         input bit aligned, input int mid_act);
    bit ok = 1;
    int hl = 0, hr = 0, ps = 0;
    if (!aligned) wait_ps(ok);
    if (ok) begin
      for (int i = 0; i < P; i++) begin
        if (mid_act >= 0 && i == P / 2) output_action = 3'(mid_act);
        @(negedge clk);
        hl += int'(pwm_l);
        hr += int'(pwm_r);
        ps += int'(period_start);
      end
      check({name, "_width_l"}, hl, exp_l);
      check({name, "_width_r"}, hr, exp_r);
      check({name, "_strobes"}, ps, 1);
    end
  endtask

  task automatic set_action(input logic [2:0] a);
    @(posedge clk); #1;
    output_action = a;
  endtask

  initial begin
    bit ok;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("reset_pwm_l", pwm_l, 0);
    check("reset_pwm_r", pwm_r, 0);
    check("reset_period_start", period_start, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("first_period_start", period_start, 1);

    measure("stop", 60, 60, 0, -1);
    set_action(3'd1);
    measure("forward", SOFT ? 65 : 80, SOFT ? 55 : 40, 0, -1);
    measure("mid_change", SOFT ? 70 : 80, SOFT ? 50 : 40, 1, 4);
    measure("spin", SOFT ? 75 : 80, SOFT ? 55 : 80, 1, -1);
    set_action(3'd5);
    measure("backward", SOFT ? 75 : 40, SOFT ? 65 : 80, 0, -1);
    set_action(3'd7);
    measure("illegal", SOFT ? 65 : 60, SOFT ? 65 : 60, 0, -1);
    repeat (3) wait_ps(ok);

    // Change lands inside the cnt==0 cycle, before its sampling edge.
    output_action = 3'd1;
    measure("sample_cycle", SOFT ? 65 : 80, SOFT ? 55 : 40, 1, -1);
    output_action = 3'd0;
    repeat (3) wait_ps(ok);
    output_action = 3'd1;
    for (int k = 0; k < 5; k++) measure("ramp", ramp_l[k], ramp_r[k], 1, -1);

    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    output_action = 3'd0;
    @(posedge clk);
    @(negedge clk);
    check("midpulse_reset_pwm_l", pwm_l, 0);
    check("midpulse_reset_pwm_r", pwm_r, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("restart_period_start", period_start, 1);
    measure("after_reset", 60, 60, 1, -1);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(1, 2 * P)) @(posedge clk);
      #1;
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        reset = 1'b0;
      end
      output_action = 3'($urandom_range(0, 7));
    end
    repeat (2 * P + 2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
